systolic_skew_feeder: RTL

Upstream input stage for `tt_um_systolic_array`. It accepts one row-parallel vector of five operands per handshake and re-times the vector into the diagonal wavefront the array needs: lane k is delayed k extra cycles. Outputs `data_out1..data_out5` connect directly to the array's `data_in1..data_in5`. After each frame the block flushes the array with zero vectors and reports completion.

---
 rtl/systolic_pkg.sv | 18 +
 rtl/skew_delay_line.sv | 47 ++++
 rtl/systolic_skew_feeder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants and types for the systolic array front end
//
// Purpose: lane count, default operand width, drain length and the feeder
// FSM state type used by the skew feeder and its delay lines.

package systolic_pkg;

  localparam int SA_LANES        = 5;
  localparam int SA_WIDTH        = 8;
  localparam int SA_DRAIN_CYCLES = SA_LANES - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - fixed-depth data+valid register chain for one lane
//
// Purpose: delays one operand lane by DEPTH clock edges. The chain shifts on
// every edge; there is no enable because the downstream array has none.
// Ports:
//   clk        clock, rising edge
//   clear      synchronous active-high reset, empties the chain
//   in_data    operand entering stage 0
//   in_valid   marks in_data as a real operand (0 = fill)
//   out_data   operand leaving the last stage
//   out_valid  valid bit travelling with out_data

module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i]  <= '0;
        r_valid[i] <= 1'b0;
      end
    end else begin
      r_data[0]  <= in_data;
      r_valid[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i]  <= r_data[i-1];
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  assign out_data  = r_data[DEPTH-1];
  assign out_valid = r_valid[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - skews row vectors into a diagonal wavefront for the array
//
// Purpose: accepts one 5-lane vector per handshake, delays lane k by k extra
// edges, flushes the array with zero vectors after each frame and flags
// frame completion and mid-frame bubbles.
// Ports:
//   clk                  clock, rising edge
//   clear                synchronous active-high reset (shared with the array)
//   in_valid / in_ready  upstream vector handshake
//   in_data              lane k in bits [k*WIDTH +: WIDTH]
//   in_last              final vector of a frame, sampled on handshake
//   data_out1..5         skewed operands to the array
//   out_valid            bit k: data_out(k+1) carries a real operand
//   frame_done           one-cycle pulse as the last operand leaves lane 4
//   underrun             sticky flag, set by a bubble inside a frame

module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SA_LANES*WIDTH-1:0] in_data,
  input  logic                      in_last,
  output logic [WIDTH-1:0]          data_out1,
  output logic [WIDTH-1:0]          data_out2,
  output logic [WIDTH-1:0]          data_out3,
  output logic [WIDTH-1:0]          data_out4,
  output logic [WIDTH-1:0]          data_out5,
  output logic [SA_LANES-1:0]       out_valid,
  output logic                      frame_done,
  output logic                      underrun
);

  localparam logic [2:0] DRAIN_LAST = 3'(SA_DRAIN_CYCLES - 1);

  feeder_state_t       r_state;
  feeder_state_t       w_state_next;
  logic [2:0]          r_drain_cnt;
  logic [2:0]          w_drain_cnt_next;
  logic                w_accept;
  logic [SA_LANES-1:0] r_marker;
  logic                r_underrun;
  logic [WIDTH-1:0]    w_lane_out [SA_LANES];
  logic [SA_LANES-1:0] w_lane_valid;

  // in_ready depends only on registered state and clear, never on in_valid.
  assign in_ready = !clear && (r_state != DRAIN);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state     <= IDLE;
      r_drain_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_drain_cnt_next = r_drain_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next     = in_last ? DRAIN : STREAM;
          w_drain_cnt_next = 3'd0;
        end
      end
      STREAM: begin
        if (w_accept && in_last) begin
          w_state_next     = DRAIN;
          w_drain_cnt_next = 3'd0;
        end
      end
      DRAIN: begin
        // Zero vectors are injected automatically because nothing is accepted.
        if (r_drain_cnt == DRAIN_LAST) begin
          w_state_next     = IDLE;
          w_drain_cnt_next = 3'd0;
        end else begin
          w_drain_cnt_next = r_drain_cnt + 3'd1;
        end
      end
      default: begin
        w_state_next     = IDLE;
        w_drain_cnt_next = 3'd0;
      end
    endcase
  end

  // The marker chain is as deep as lane 4, so its tail lines up with the
  // last operand of the frame leaving the final lane.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_marker   <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_marker <= {r_marker[SA_LANES-2:0], w_accept & in_last};
      if (r_state == STREAM && !w_accept) begin
        r_underrun <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < SA_LANES; g++) begin : g_lane
    logic [WIDTH-1:0] w_stage0;
    assign w_stage0 = w_accept ? in_data[g*WIDTH +: WIDTH] : '0;

    skew_delay_line #(
      .DEPTH (g + 1),
      .WIDTH (WIDTH)
    ) u_line (
      .clk       (clk),
      .clear     (clear),
      .in_data   (w_stage0),
      .in_valid  (w_accept),
      .out_data  (w_lane_out[g]),
      .out_valid (w_lane_valid[g])
    );
  end

  assign data_out1  = w_lane_out[0];
  assign data_out2  = w_lane_out[1];
  assign data_out3  = w_lane_out[2];
  assign data_out4  = w_lane_out[3];
  assign data_out5  = w_lane_out[4];
  assign out_valid  = w_lane_valid;
  assign frame_done = r_marker[SA_LANES-1];
  assign underrun   = r_underrun;

endmodule
